// File: rtl/seqdet_pkg.sv
// Shared types and constants for the serial sequence-detector path.
// Used by the serializer front end and the detector-side bench.
package seqdet_pkg;

    localparam int SEQDET_WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register for seq_serializer. Lets the producer hand
// over the next word while the current one is still shifting.
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full,
    output logic             in_ready
);

    always_ff @(posedge clk) begin
        if (clr) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Ready also drops during clr so nothing is taken while the block is cleared.
    assign in_ready = !hold_full && !clr;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit
// per clock out on sout, back-to-back words with no idle gap.
module seq_serializer
    import seqdet_pkg::*;
#(
    parameter int WIDTH     = SEQDET_WORD_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output ser_state_t       dbg_state
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             accept, last_bit, shifter_free, load_hold, drain;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_data is sampled only at that edge, and in_valid may stay high across
    // back-to-back words. in_ready depends only on registers and clr.
    assign accept       = in_valid && in_ready;
    assign last_bit     = (state == SHIFT) && (cnt == CNT_LAST);
    assign drain        = last_bit && hold_full;
    assign shifter_free = (state == IDLE) || (last_bit && !hold_full);
    assign load_hold    = accept && !shifter_free;

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .clr       (clr),
        .load      (load_hold),
        .drain     (drain),
        .in_data   (in_data),
        .hold_data (hold_data),
        .hold_full (hold_full),
        .in_ready  (in_ready)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                    sh_n    = in_data;
                    cnt_n   = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_n = '0;
                    // A held word has priority; it cannot coincide with an accept.
                    if (hold_full) begin
                        sh_n = hold_data;
                    end else if (accept) begin
                        sh_n = in_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    sh_n  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sout       = (state == SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
    assign sout_valid = (state == SHIFT);
    assign sout_last  = last_bit;
    assign busy       = (state == SHIFT) || hold_full;
    assign dbg_state  = state;

endmodule
